// File: rtl/aes_op_sched.sv
// Round-robin scheduler sharing one multicycle AES core between requesters A and B.
// Optional build macro AES_OP_SCHED_ZEROIZE_EN clears operand/result regs after each response.
module aes_op_sched #(
  parameter int CORE_LAT = 4,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic         a_mode,
  input  logic [127:0] a_in,
  input  logic [127:0] a_key,
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  output logic [127:0] a_rsp_data,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic         b_mode,
  input  logic [127:0] b_in,
  input  logic [127:0] b_key,
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic [127:0] b_rsp_data,
  output logic         core_mode,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(CORE_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     result;
  logic             gnt_vld;
  logic             gnt;
  logic             accept;
  logic             capture;
  logic             rsp_hs;

  // grant encoding: 0 = A, 1 = B
  always_comb begin
    gnt_vld = a_req_valid | b_req_valid;
    gnt     = (a_req_valid & b_req_valid) ? ~last_grant : b_req_valid;
  end

  always_comb begin
    state_nxt   = state;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_hs      = 1'b0;
    unique case (state)
      IDLE: begin
        a_req_ready = gnt_vld & ~gnt;
        b_req_ready = gnt_vld & gnt;
        accept      = gnt_vld;
        if (gnt_vld) state_nxt = RUN;
      end
      RUN: begin
        capture = (cnt == '0);
        if (capture) state_nxt = RESP;
      end
      RESP: begin
        a_rsp_valid = ~owner;
        b_rsp_valid = owner;
        rsp_hs      = owner ? b_rsp_ready : a_rsp_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_rsp_data = result;
  assign b_rsp_data = result;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      core_mode  <= 1'b0;
      core_in    <= '0;
      core_key   <= '0;
      result     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= gnt;
        last_grant <= gnt;
        cnt        <= LAT_M1;
        core_mode  <= gnt ? b_mode : a_mode;
        core_in    <= gnt ? b_in : a_in;
        core_key   <= gnt ? b_key : a_key;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) result <= core_out;
`ifdef AES_OP_SCHED_ZEROIZE_EN
      if (rsp_hs) begin
        core_in  <= '0;
        core_key <= '0;
        result   <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_aes_op_sched.sv
// Scoreboard bench for aes_op_sched with a behavioural core model that
// only yields the right answer once its inputs have been stable CORE_LAT cycles.
module tb_aes_op_sched;

  localparam int L = 4;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_req_valid = 1'b0;
  logic         a_req_ready;
  logic         a_mode = 1'b0;
  logic [127:0] a_in = '0;
  logic [127:0] a_key = '0;
  logic         a_rsp_valid;
  logic         a_rsp_ready = 1'b0;
  logic [127:0] a_rsp_data;
  logic         b_req_valid = 1'b0;
  logic         b_req_ready;
  logic         b_mode = 1'b0;
  logic [127:0] b_in = '0;
  logic [127:0] b_key = '0;
  logic         b_rsp_valid;
  logic         b_rsp_ready = 1'b0;
  logic [127:0] b_rsp_data;
  logic         core_mode;
  logic [127:0] core_in;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rr_a = 0;
  int rr_b = 0;

  aes_op_sched #(.CORE_LAT(L), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_mode(a_mode), .a_in(a_in), .a_key(a_key),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_mode(b_mode), .b_in(b_in), .b_key(b_key),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_rsp_data(b_rsp_data),
    .core_mode(core_mode), .core_in(core_in), .core_key(core_key),
    .core_out(core_out), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_fn(logic m, logic [127:0] i,
                                           logic [127:0] k);
    if (m && i == PT && k == KEY) return CT;
    if (!m && i == CT && k == KEY) return PT;
    if (m) return (i ^ k) + 128'd1;
    return {i[63:0], i[127:64]} ^ ~k;
  endfunction

  // core model: wrong answer until inputs have been stable for L cycles
  int           stab = 0;
  logic [256:0] prev = '0;
  always @(negedge clk) begin
    if ({core_mode, core_in, core_key} !== prev) begin
      prev = {core_mode, core_in, core_key};
      stab = 1;
    end else if (stab < 1000) begin
      stab = stab + 1;
    end
  end
  assign core_out = (stab >= L) ? core_fn(core_mode, core_in, core_key)
                                : ~core_fn(core_mode, core_in, core_key);

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // response-ready drivers: 0 = low, 1 = high, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_rsp_ready = (rr_a == 2) ? 1'($urandom % 2) : (rr_a == 1);
      b_rsp_ready = (rr_b == 2) ? 1'($urandom % 2) : (rr_b == 1);
    end
  end

  typedef struct {
    bit           who;
    logic         m;
    logic [127:0] i;
    logic [127:0] k;
    logic [127:0] d;
    int           acc;
  } op_t;

  op_t          q[$];
  bit           last_g = 1'b1;
  bit           zchk = 1'b0;
  logic [127:0] z_i;
  logic [127:0] z_k;
  int           acc_log[$];
  bit           who_log[$];

  always @(negedge clk) begin
    bit  g_v;
    bit  g;
    bit  vis;
    op_t e;
    if (rst) begin
      q.delete();
      last_g = 1'b1;
      zchk   = 1'b0;
      chk("rst_busy", busy, 0);
    end else begin
      if (zchk) begin
        zchk = 1'b0;
`ifdef AES_OP_SCHED_ZEROIZE_EN
        chk("zero_in", core_in, 0);
        chk("zero_key", core_key, 0);
`else
        chk("keep_in", core_in, z_i);
        chk("keep_key", core_key, z_k);
`endif
      end
      g_v = 1'b0;
      g   = 1'b0;
      if (q.size() == 0) begin
        if (a_req_valid && b_req_valid) begin
          g_v = 1'b1;
          g   = !last_g;
        end else if (a_req_valid) begin
          g_v = 1'b1;
        end else if (b_req_valid) begin
          g_v = 1'b1;
          g   = 1'b1;
        end
      end
      chk("a_req_ready", a_req_ready, g_v && !g);
      chk("b_req_ready", b_req_ready, g_v && g);
      chk("busy", busy, q.size() != 0);
      if (q.size() != 0) begin
        e   = q[0];
        vis = (cyc >= e.acc + L);
        chk("a_rsp_valid", a_rsp_valid, vis && !e.who);
        chk("b_rsp_valid", b_rsp_valid, vis && e.who);
        chk("core_mode", core_mode, e.m);
        chk("core_in", core_in, e.i);
        chk("core_key", core_key, e.k);
        if (vis) chk("rsp_data", e.who ? b_rsp_data : a_rsp_data, e.d);
        if (vis && (e.who ? b_rsp_ready : a_rsp_ready)) begin
          void'(q.pop_front());
          zchk = 1'b1;
          z_i  = e.i;
          z_k  = e.k;
        end
      end else begin
        chk("idle_a_rsp_valid", a_rsp_valid, 0);
        chk("idle_b_rsp_valid", b_rsp_valid, 0);
      end
      if (g_v) begin
        e.who = g;
        e.m   = g ? b_mode : a_mode;
        e.i   = g ? b_in : a_in;
        e.k   = g ? b_key : a_key;
        e.d   = core_fn(e.m, e.i, e.k);
        e.acc = cyc + 1;
        q.push_back(e);
        last_g = g;
        acc_log.push_back(cyc + 1);
        who_log.push_back(g);
      end
    end
  end

  task automatic do_req(input bit who, input logic m, input logic [127:0] i,
                        input logic [127:0] k);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    if (who) begin
      b_req_valid = 1'b1; b_mode = m; b_in = i; b_key = k;
    end else begin
      a_req_valid = 1'b1; a_mode = m; a_in = i; a_key = k;
    end
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (who ? (b_req_valid && b_req_ready)
              : (a_req_valid && a_req_ready)) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: requester %0d never accepted", who);
    end
    @(posedge clk);
    #1;
    if (who) b_req_valid = 1'b0;
    else a_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit who, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (who ? b_rsp_valid : a_rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: requester %0d got no response", who);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d ops outstanding", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0;
    #1;
    chk("rst_busy0", busy, 0);
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_core_key", core_key, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rr_a = 1;
    rr_b = 1;

    // single encrypt, then decrypt round trip
    do_req(0, 1'b1, PT, KEY);
    t0 = acc_log[$];
    wait_rsp(0, ok);
    if (ok) begin
      chk("t1_latency", 128'(cyc - t0), 128'(L));
      chk("t1_data", a_rsp_data, CT);
    end
    drain();
    do_req(0, 1'b0, CT, KEY);
    wait_rsp(0, ok);
    if (ok) chk("t4_data", a_rsp_data, PT);
    drain();

    // tie from reset: alternate A,B with L+2 spacing
    do_reset();
    acc_log.delete();
    who_log.delete();
    fork
      begin
        for (int j = 0; j < 3; j++) do_req(0, 1'($urandom), r128(), r128());
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, 1'($urandom), r128(), r128());
      end
    join
    drain();
    chk("tie_count", 128'(who_log.size()), 128'd6);
    for (int j = 0; j < who_log.size(); j++) begin
      chk("tie_order", 128'(who_log[j]), 128'(j % 2));
      if (j > 0)
        chk("tie_spacing", 128'(acc_log[j] - acc_log[j-1]), 128'(L + 2));
    end

    // backpressure on B while A waits
    rr_b = 0;
    fork
      do_req(1, 1'b1, r128(), r128());
      begin
        repeat (2) @(posedge clk);
        do_req(0, 1'b0, r128(), r128());
      end
      begin
        logic [127:0] d0;
        wait_rsp(1, ok);
        d0 = b_rsp_data;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          chk("bp_valid", b_rsp_valid, 1);
          chk("bp_data", b_rsp_data, d0);
          chk("bp_a_ready", a_req_ready, 0);
        end
        rr_b = 1;
      end
    join
    drain();

    // reset in the middle of RUN discards the op
    do_req(0, 1'b1, r128(), r128());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_key", core_key, 0);
    chk("mid_rst_in", core_in, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    who_log.delete();
    fork
      do_req(0, 1'b1, r128(), r128());
      do_req(1, 1'b0, r128(), r128());
    join
    drain();
    if (who_log.size() > 0) chk("post_rst_first", 128'(who_log[0]), 0);
    else chk("post_rst_first_cnt", 0, 1);

    // random traffic with random response backpressure
    rr_a = 2;
    rr_b = 2;
    fork
      begin
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 8)) @(posedge clk);
          do_req(0, 1'($urandom), r128(), r128());
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 8)) @(posedge clk);
          do_req(1, 1'($urandom), r128(), r128());
        end
      end
    join
    drain();
    rr_a = 1;
    rr_b = 1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_op_sched.md
Name: aes_op_sched

Overview:
- Schedules a single shared AES core (aes_encrypt/aes_decrypt pair, selected by mode) between two requesters, A and B.
- Arbitration is round-robin.
- Per operation: latch operands, hold them stable on the core inputs for a fixed multicycle window, capture the result, return it to the owning requester over a valid/ready response channel.
- Sits between the host-side request logic and the AES datapath that top instantiates.

Parameters:
- CORE_LAT, 4: cycles from operand issue to result capture. Legal range 1..255. Covers the core's combinational multicycle path.
- CNT_W, 8: width of the latency down-counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- a_req_valid  input  1  requester A has an operation
- a_req_ready  output  1  scheduler accepts A's operation this cycle
- a_mode  input  1  1 = encrypt, 0 = decrypt
- a_in  input  128  A's plaintext/ciphertext block
- a_key  input  128  A's key
- a_rsp_valid  output  1  result for A is available
- a_rsp_ready  input  1  A consumes the result
- a_rsp_data  output  128  result for A
- b_req_valid, b_req_ready, b_mode, b_in, b_key, b_rsp_valid, b_rsp_ready, b_rsp_data: identical to the A ports, for requester B
- core_mode  output  1  mode driven to the core
- core_in  output  128  block driven to the core
- core_key  output  128  key driven to the core
- core_out  input  128  mode-selected core result
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=B (so A wins the first tie), owner=A, counter=0.
  - core_mode/core_in/core_key/result registers = 0.
  - All *_ready and *_rsp_valid = 0. busy = 0.
- States: IDLE -> RUN -> RESP -> IDLE.
- IDLE:
  - grant is combinational. Only one valid: grant it. Both valid: grant the one != last_grant. Neither: no grant.
  - x_req_ready = (state==IDLE) & (grant==x). The other ready stays 0.
  - Handshake (valid & ready) at edge t: latch mode/in/key into the core_* registers, owner=grant, last_grant=grant, counter=CORE_LAT-1, go to RUN.
- RUN:
  - core_* held stable. Counter decrements each cycle.
  - At counter==0: capture core_out into the result register and go to RESP.
  - The capture edge is t+CORE_LAT.
- RESP:
  - owner_rsp_valid=1 and owner_rsp_data=result. The other requester sees rsp_valid=0.
  - Valid and data hold until owner_rsp_ready=1, then go to IDLE.
  - rsp_ready from the non-owner is ignored.
- Throughput and latency:
  - Minimum request-accept to rsp_valid: CORE_LAT cycles.
  - Minimum accept-to-accept: CORE_LAT+2 cycles.
- Both requesters valid continuously: grants alternate A, B, A, B...
- Request valid arriving during RUN/RESP is not accepted (ready=0). It is considered in the next IDLE cycle. Requesters must hold valid and operands until accepted.
- rsp_ready held high in advance: handshake completes on the first RESP cycle.
- rsp_data is defined only while rsp_valid=1. Both rsp_data outputs carry the result register.
- Reset mid-operation: the operation is discarded with no response, and all state returns to reset values.

Optional Feature:
- Macro: AES_OP_SCHED_ZEROIZE_EN
- Defined: on the response handshake edge, core_in, core_key and the result register clear to 0. Key material does not persist on the core inputs while idle.
- Undefined: these registers retain the last operation's values until the next accept.
- Arbitration, handshake and timing are identical in both builds.

Test Plan:
1. Single op, CORE_LAT=4: A requests mode=1, in=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f, rsp_ready=1 -> a_req_ready high in IDLE; a_rsp_valid 4 cycles after accept with data 0x69c4e0d86a7b0430d8cdb78070b4c55a; b_rsp_valid stays 0.
2. Tie: A and B both valid from reset, both rsp_ready=1 -> grant order A, B, A, B. Accepts spaced 6 cycles apart.
3. Backpressure: B op completes with b_rsp_ready=0 for 10 cycles -> b_rsp_valid and data stable for all 10 cycles; a_req_ready=0 throughout; IDLE re-entered the cycle after b_rsp_ready=1.
4. Decrypt round trip: A sends mode=0 with the test-1 ciphertext and key -> response data 0x00112233445566778899aabbccddeeff.
5. Reset mid-RUN: assert rst two cycles after accept -> rsp_valid never asserts; busy=0 and core_key=0 immediately. A subsequent tie is granted to A.
6. ZEROIZE_EN defined: after the response handshake, core_key=0 and core_in=0 on the next cycle. Macro undefined: they retain the test-1 values.
